// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 modified Booth multiplier, signed or unsigned per operation.
// Retires two multiplier bits per EXEC cycle; op_start/op_clear/op_done handshake.
module booth_r4_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               op_signed,
  input  logic               op_start,
  input  logic               op_clear,
  output logic               op_busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = $clog2(ITER) + 1;
  localparam int AW   = 2 * WIDTH + 2;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  if (WIDTH < 4 || WIDTH % 2 != 0) begin : g_bad_width
    $error("booth_r4_multiplier: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    EXEC    = 2'b01,
    DONE    = 2'b10,
    ILLEGAL = 2'b11
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH+2:0]   mlr_q;
  logic [AW-1:0]      mcd_q;
  logic [AW-1:0]      acc_q;
  logic [AW-1:0]      acc_d;
  logic [AW-1:0]      pp;
  logic [2*WIDTH-1:0] result_q;
  logic               busy_q;
  logic               done_q;
  logic               ext_m;
  logic               ext_c;
  logic               clr;

  assign ext_m = op_signed & multiplier[WIDTH-1];
  assign ext_c = op_signed & multiplicand[WIDTH-1];
  assign clr   = reset | op_clear | (state_q == ILLEGAL);

  // mlr_q[2:0] is the current Booth triple; both operand registers shift
  // by two each cycle so the digit weight is carried by mcd_q itself.
  always_comb begin
    pp = '0;
    unique case (mlr_q[2:0])
      3'b001, 3'b010: pp = mcd_q;
      3'b011:         pp = mcd_q << 1;
      3'b100:         pp = -(mcd_q << 1);
      3'b101, 3'b110: pp = -mcd_q;
      default:        pp = '0;
    endcase
    acc_d = acc_q + pp;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      count_q  <= '0;
      mlr_q    <= '0;
      mcd_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_start) begin
            mlr_q   <= {{2{ext_m}}, multiplier, 1'b0};
            mcd_q   <= {{(WIDTH + 2){ext_c}}, multiplicand};
            acc_q   <= '0;
            count_q <= '0;
            state_q <= EXEC;
            busy_q  <= 1'b1;
          end
        end
        EXEC: begin
          acc_q <= acc_d;
          mlr_q <= mlr_q >> 2;
          mcd_q <= mcd_q << 2;
          if (count_q == LAST) begin
            count_q  <= '0;
            result_q <= acc_d[2*WIDTH-1:0];
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign op_busy = busy_q;
  assign op_done = done_q;
  assign result  = result_q;

endmodule
